// File: rtl/wallace_divider_32_16.sv
`default_nettype none
// ============================================================================
// Module   : wallace_divider_32_16
// Purpose  : 32/16 unsigned restoring divider, the inverse of a 16x16
//            multiplier: dividend = quotient*divisor + remainder.
//            The operation is classified for one cycle (divide-by-zero,
//            quotient overflow, or normal). A normal operation then runs
//            16 radix-2 restoring steps, one per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   dividend/divisor presented
//   in_ready     out  1   high only in IDLE
//   dividend     in  32   unsigned dividend
//   divisor      in  16   unsigned divisor
//   out_valid    out  1   result fields valid (DONE state)
//   out_ready    in   1   downstream accepts result
//   quotient     out 16   unsigned quotient
//   remainder    out 16   unsigned remainder
//   div_by_zero  out  1   divisor was zero
//   overflow     out  1   quotient does not fit in 16 bits
// ============================================================================
module wallace_divider_32_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  LAST_STEP = 5'd15;
  localparam logic [15:0] ALL_ONES  = 16'hFFFF;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] divisor_q, divisor_d;
  // hi holds the 17-bit partial remainder; it is loaded with dividend[31:16].
  logic [16:0] hi_q, hi_d;
  // lo starts as dividend[15:0]. Each step shifts one dividend bit out of
  // the top and one quotient bit in at the bottom, so after 16 steps lo
  // holds the quotient.
  logic [15:0] lo_q, lo_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [16:0] w_shift;
  logic [17:0] w_diff;
  logic        w_ge;
  logic [16:0] w_rem_next;
  logic [15:0] w_lo_next;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in 17 bits and the restored result fits back
  // into 16 bits.
  always_comb begin
    w_shift    = {hi_q[15:0], lo_q[15]};
    w_diff     = {1'b0, w_shift} - {2'b00, divisor_q};
    w_ge       = ~w_diff[17];
    w_rem_next = w_ge ? w_diff[16:0] : w_shift;
    w_lo_next  = {lo_q[14:0], w_ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hi_d      = {1'b0, dividend[31:16]};
          lo_d      = dividend[15:0];
          divisor_d = divisor;
          cnt_d     = 5'd0;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (divisor_q == 16'd0) begin
          // Divide-by-zero takes priority over the overflow test.
          dbz_d       = 1'b1;
          quotient_d  = ALL_ONES;
          remainder_d = lo_q;
          state_d     = DONE;
        end else if (hi_q[15:0] >= divisor_q) begin
          ovf_d       = 1'b1;
          quotient_d  = ALL_ONES;
          remainder_d = 16'd0;
          state_d     = DONE;
        end else begin
          cnt_d   = 5'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        hi_d = w_rem_next;
        lo_d = w_lo_next;
        if (cnt_q == LAST_STEP) begin
          // The counter holds at 15 on exit and is cleared at the next accept.
          quotient_d  = w_lo_next;
          remainder_d = w_rem_next[15:0];
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      divisor_q   <= 16'd0;
      hi_q        <= 17'd0;
      lo_q        <= 16'd0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_divider_32_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_divider_32_16
// Purpose  : Directed self-checking bench for wallace_divider_32_16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wallace_divider_32_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_divider_32_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Presents one operation, then scrambles the inputs. lat is the number of
  // rising edges after the accept edge until out_valid is seen (41 on timeout).
  task automatic do_op(input logic [31:0] dd, input logic [15:0] dv, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom();
    divisor  = 16'($urandom());
    lat = 0;
    while (out_valid !== 1'b1 && lat <= 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, required rdy=1 vld=0 q=0 r=0 dbz=0 ovf=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    do_op(32'h0000_0015, 16'h0004, lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 17", lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h0005, 16'h0001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: q=%h r=%h dbz=%b ovf=%b required q=0005 r=0001 dbz=0 ovf=0",
               quotient, remainder, div_by_zero, overflow);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_return_idle: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_roundtrip();
    int lat;
    logic [15:0] a, b, r;
    logic [31:0] p;
    do_op(32'hFFFE_0001, 16'hFFFF, lat);
    checks++;
    if ({lat == 17, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL roundtrip_max: lat=%0d q=%h r=%h dbz=%b ovf=%b required lat=17 q=ffff r=0000 flags 0",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
    // Largest normal quotient: 0x4FFFF / 5 = 65535 rem 4.
    do_op(32'h0004_FFFF, 16'h0005, lat);
    checks++;
    if ({lat == 17, quotient, remainder, overflow} !== {1'b1, 16'hFFFF, 16'h0004, 1'b0}) begin
      errors++;
      $display("FAIL roundtrip_edge: lat=%0d q=%h r=%h ovf=%b required lat=17 q=ffff r=0004 ovf=0",
               lat, quotient, remainder, overflow);
    end
    release_result();
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      r = 16'($urandom_range(0, int'(b) - 1));
      p = {16'd0, a} * {16'd0, b} + {16'd0, r};
      do_op(p, b, lat);
      checks++;
      if ({lat == 17, quotient, remainder, div_by_zero, overflow} !== {1'b1, a, r, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL roundtrip_sweep: p=%h b=%h lat=%0d q=%h r=%h required q=%h r=%h lat=17 flags 0",
                 p, b, lat, quotient, remainder, a, r);
      end
      release_result();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(32'h1234_5678, 16'h0000, lat);
    checks++;
    if ({lat == 1, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h5678, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL div_zero: lat=%0d q=%h r=%h dbz=%b ovf=%b required lat=1 q=ffff r=5678 dbz=1 ovf=0",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
    // Upper half would also overflow; divide-by-zero must win.
    do_op(32'hFFFF_0000, 16'h0000, lat);
    checks++;
    if ({lat == 1, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL div_zero_priority: lat=%0d q=%h r=%h dbz=%b ovf=%b required lat=1 q=ffff r=0000 dbz=1 ovf=0",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
    checks++;
    if ({in_ready, div_by_zero} !== 2'b10) begin
      errors++;
      $display("FAIL div_zero_clear: rdy=%b dbz=%b required rdy=1 dbz=0", in_ready, div_by_zero);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(32'h0001_0000, 16'h0001, lat);
    checks++;
    if ({lat == 1, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL overflow: lat=%0d q=%h r=%h dbz=%b ovf=%b required lat=1 q=ffff r=0000 dbz=0 ovf=1",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
    // Upper half exactly equal to the divisor is already an overflow.
    do_op(32'h0005_0000, 16'h0005, lat);
    checks++;
    if ({lat == 1, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL overflow_equal: lat=%0d q=%h r=%h dbz=%b ovf=%b required lat=1 q=ffff r=0000 dbz=0 ovf=1",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_busy;
    int bad_hold;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    #1;
    // Keep offering a different (overflowing) operation while busy.
    dividend = 32'hFFFF_FFFF;
    divisor  = 16'h0001;
    lat = 0;
    bad_busy = 0;
    while (out_valid !== 1'b1 && lat <= 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid !== 1'b1 && in_ready !== 1'b0) bad_busy++;
    end
    in_valid = 1'b0;
    checks++;
    if ({lat == 17, bad_busy == 0} !== 2'b11) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d busy_cycles_ready=%0d required lat=17 and 0", lat, bad_busy);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'd333, 16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL busy_result: q=%0d r=%0d dbz=%b ovf=%b required q=333 r=1 flags 0",
               quotient, remainder, div_by_zero, overflow);
    end
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !==
          {1'b1, 1'b0, 16'd333, 16'd1, 1'b0, 1'b0}) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad_hold);
    end
    release_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int stale;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'h1234_5678;
    divisor  = 16'h9ABC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Edges N+1..N+8: now in the cycle performing step 8.
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b required rdy=1 vld=0 q=0 r=0 flags 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_no_stale: out_valid high %0d cycles, required 0", stale);
    end
    do_op(32'd100, 16'd7, lat);
    checks++;
    if ({lat == 17, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'd14, 16'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_next_op: lat=%0d q=%0d r=%0d dbz=%b ovf=%b required lat=17 q=14 r=2 flags 0",
               lat, quotient, remainder, div_by_zero, overflow);
    end
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 32'd0;
    divisor   = 16'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
